hazard_ctrl: RTL and testbench

- Hazard, forwarding and stall controller for the 5-stage MIPS pipeline.
- Generates the execute-stage operand forwarding selects (ForwardAE/ForwardBE) and the decode-stage branch-compare forwards.
- Generates load-use and branch stalls, pipeline flushes, and a data-memory wait freeze.
- The wait freeze is sequenced by a small FSM with a timeout watchdog.

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_fwd_sel.sv | 37 +++
 rtl/hazard_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Constants shared by the pipeline hazard controller and its sub-module:
//   - execute-stage forward select encodings
//   - memory-wait FSM state encoding
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  // Execute operand mux select values. Encodings 3..7 are never produced.
  localparam logic [2:0] FWD_REG     = 3'd0;
  localparam logic [2:0] FWD_RESULTW = 3'd1;
  localparam logic [2:0] FWD_ALUOUTM = 3'd2;

  // Memory-wait sequencer states.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Single-operand forward priority selector for the execute stage. The memory
// stage result is newer than the writeback result, so it wins when both match.
// Register 0 is hard-wired to zero and is never forwarded.
// Ports:
//   i_src          execute-stage source register of this operand
//   i_reg_write_m  memory-stage instruction writes the register file
//   i_write_reg_m  memory-stage destination register
//   i_reg_write_w  writeback-stage instruction writes the register file
//   i_write_reg_w  writeback-stage destination register
//   o_sel          FWD_REG / FWD_RESULTW / FWD_ALUOUTM
// -----------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_src,
  input  logic              i_reg_write_m,
  input  logic [ADDR_W-1:0] i_write_reg_m,
  input  logic              i_reg_write_w,
  input  logic [ADDR_W-1:0] i_write_reg_w,
  output logic [2:0]        o_sel
);

  always_comb begin
    // NOTE: default first so every path assigns o_sel and no latch is inferred.
    o_sel = FWD_REG;
    if (i_reg_write_m && (i_write_reg_m != '0) && (i_write_reg_m == i_src)) begin
      o_sel = FWD_ALUOUTM;
    end else if (i_reg_write_w && (i_write_reg_w != '0) && (i_write_reg_w == i_src)) begin
      o_sel = FWD_RESULTW;
    end
  end

endmodule : hazard_fwd_sel

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard, forwarding and stall controller for the 5-stage MIPS pipeline.
//   - execute operand forwards (two hazard_fwd_sel instances, Rs and Rt)
//   - decode branch-compare forwards from the memory stage
//   - load-use and branch stalls with execute-stage bubble
//   - full pipeline freeze while data memory is busy, sequenced by a
//     RUN/WAIT/ERROR FSM whose counter trips a sticky error after
//     MEM_TIMEOUT consecutive wait cycles (ERROR is left only by reset)
// Every output is forced to 0 while i_rst is high.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_RsD/i_RtD, i_RsE/i_RtE      decode / execute source registers
//   i_WriteReg{E,M,W}             destination register per stage
//   i_RegWrite{E,M,W}             register-write enable per stage
//   i_MemtoReg{E,M}               instruction is a load
//   i_BranchD, i_PCSrcD           branch in decode, branch taken
//   i_MemReqM, i_MemReadyM        data memory request / ready in M
//   o_Forward{A,B}E               execute operand selects
//   o_Forward{A,B}D               decode compare select ALUOutM
//   o_Stall{F,D,E,M,W}            hold pipeline register
//   o_Flush{D,E}                  bubble pipeline register
//   o_MemErr                      sticky memory timeout
//   o_StallCycles                 saturating stall-cycle counter, present only
//                                 when HAZARD_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int MEM_TIMEOUT    = 255,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_PCSrcD,
  input  logic                     i_MemReqM,
  input  logic                     i_MemReadyM,
  output logic [2:0]               o_ForwardAE,
  output logic [2:0]               o_ForwardBE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_StallE,
  output logic                     o_StallM,
  output logic                     o_StallW,
  output logic                     o_FlushD,
  output logic                     o_FlushE,
`ifdef HAZARD_PERF_CNT_EN
  output logic                     o_MemErr,
  output logic [PERF_CNT_WIDTH-1:0] o_StallCycles
`else
  output logic                     o_MemErr
`endif
);

  // Reject configurations where the timeout could not be reached by the
  // counter, or the performance counter would have no bits.
  if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > (2 ** TIMEOUT_WIDTH) - 1) ||
      (PERF_CNT_WIDTH < 1)) begin : g_bad_cfg
    $error("hazard_ctrl: MEM_TIMEOUT out of range or PERF_CNT_WIDTH < 1");
  end

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT_WIDTH'(MEM_TIMEOUT);

  // ---------------------------------------------------------------------------
  // Execute-stage forwarding
  // ---------------------------------------------------------------------------
  logic [2:0] fwd_a_sel;
  logic [2:0] fwd_b_sel;

  hazard_fwd_sel #(.ADDR_W(RF_ADDR_WIDTH)) u_fwd_a (
    .i_src         (i_RsE),
    .i_reg_write_m (i_RegWriteM),
    .i_write_reg_m (i_WriteRegM),
    .i_reg_write_w (i_RegWriteW),
    .i_write_reg_w (i_WriteRegW),
    .o_sel         (fwd_a_sel)
  );

  hazard_fwd_sel #(.ADDR_W(RF_ADDR_WIDTH)) u_fwd_b (
    .i_src         (i_RtE),
    .i_reg_write_m (i_RegWriteM),
    .i_write_reg_m (i_WriteRegM),
    .i_reg_write_w (i_RegWriteW),
    .i_write_reg_w (i_WriteRegW),
    .o_sel         (fwd_b_sel)
  );

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  logic [1:0]               state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_inc;

  assign cnt_inc = cnt_q + TIMEOUT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        // Ready in the same cycle as the request is not a wait at all.
        if (i_MemReqM && !i_MemReadyM) begin
          cnt_d   = TIMEOUT_WIDTH'(1);
          // A timeout of one means this first wait cycle already trips.
          state_d = (TIMEOUT_CNT == TIMEOUT_WIDTH'(1)) ? ST_ERROR : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_MemReadyM) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          // Counting stops at TIMEOUT_CNT (ERROR holds it), so no wrap.
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall / flush / decode-forward generation
  // ---------------------------------------------------------------------------
  logic we_nz, wm_nz;
  logic e_dst_in_d, m_dst_in_d;
  logic lw_stall, br_stall, mem_stall, front_stall;

  always_comb begin
    we_nz       = (i_WriteRegE != '0);
    wm_nz       = (i_WriteRegM != '0);
    e_dst_in_d  = (i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD);
    m_dst_in_d  = (i_WriteRegM == i_RsD) || (i_WriteRegM == i_RtD);
    // Load in E feeding the instruction in D: data is not ready until W.
    lw_stall    = i_MemtoRegE && we_nz && e_dst_in_d;
    // Branch compare in D needs an ALU result still in E, or a load in M.
    br_stall    = i_BranchD &&
                  ((i_RegWriteE && we_nz && e_dst_in_d) ||
                   (i_MemtoRegM && wm_nz && m_dst_in_d));
    mem_stall   = (i_MemReqM && !i_MemReadyM) || (state_q == ST_ERROR);
    front_stall = mem_stall || lw_stall || br_stall;
  end

  always_comb begin
    o_ForwardAE = FWD_REG;
    o_ForwardBE = FWD_REG;
    o_ForwardAD = 1'b0;
    o_ForwardBD = 1'b0;
    o_StallF    = 1'b0;
    o_StallD    = 1'b0;
    o_StallE    = 1'b0;
    o_StallM    = 1'b0;
    o_StallW    = 1'b0;
    o_FlushD    = 1'b0;
    o_FlushE    = 1'b0;
    o_MemErr    = 1'b0;
    if (!i_rst) begin
      o_ForwardAE = fwd_a_sel;
      o_ForwardBE = fwd_b_sel;
      o_ForwardAD = (i_RsD != '0) && i_RegWriteM && (i_WriteRegM == i_RsD);
      o_ForwardBD = (i_RtD != '0) && i_RegWriteM && (i_WriteRegM == i_RtD);
      o_StallF    = front_stall;
      o_StallD    = front_stall;
      // Memory freeze holds the whole pipe; rewriting W is idempotent.
      o_StallE    = mem_stall;
      o_StallM    = mem_stall;
      o_StallW    = mem_stall;
      // Bubble E only for a pure decode hazard; a freeze must not flush.
      o_FlushE    = !mem_stall && (lw_stall || br_stall);
      o_FlushD    = i_PCSrcD && !front_stall;
      o_MemErr    = (state_q == ST_ERROR);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter. StallF is set whenever any stall is.
  // ---------------------------------------------------------------------------
  logic [PERF_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign o_StallCycles = stall_cnt_q;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl. The driver applies one stimulus per cycle
// shortly after the rising edge and queues the response predicted by a
// behavioural model; the monitor pops and compares on the falling edge.
// Build with HAZARD_PERF_CNT_EN defined to cover the stall-cycle counter.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int RFW  = 5;
  localparam int TW   = 8;
  localparam int TO   = 4;
  localparam int PCW  = 4;
  localparam int unsigned PERF_MAX = (1 << PCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [RFW-1:0] rsd = '0, rtd = '0, rse = '0, rte = '0;
  logic [RFW-1:0] wre = '0, wrm = '0, wrw = '0;
  logic rwe = 0, rwm = 0, rww = 0, mre = 0, mrm = 0;
  logic brd = 0, pcs = 0, req = 0, rdy = 0;

  logic [2:0] o_ForwardAE, o_ForwardBE;
  logic o_ForwardAD, o_ForwardBD;
  logic o_StallF, o_StallD, o_StallE, o_StallM, o_StallW;
  logic o_FlushD, o_FlushE, o_MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [PCW-1:0] o_StallCycles;
`endif

  hazard_ctrl #(
    .RF_ADDR_WIDTH (RFW),
    .TIMEOUT_WIDTH (TW),
    .MEM_TIMEOUT   (TO),
    .PERF_CNT_WIDTH(PCW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_RsD       (rsd),
    .i_RtD       (rtd),
    .i_RsE       (rse),
    .i_RtE       (rte),
    .i_WriteRegE (wre),
    .i_WriteRegM (wrm),
    .i_WriteRegW (wrw),
    .i_RegWriteE (rwe),
    .i_RegWriteM (rwm),
    .i_RegWriteW (rww),
    .i_MemtoRegE (mre),
    .i_MemtoRegM (mrm),
    .i_BranchD   (brd),
    .i_PCSrcD    (pcs),
    .i_MemReqM   (req),
    .i_MemReadyM (rdy),
    .o_ForwardAE (o_ForwardAE),
    .o_ForwardBE (o_ForwardBE),
    .o_ForwardAD (o_ForwardAD),
    .o_ForwardBD (o_ForwardBD),
    .o_StallF    (o_StallF),
    .o_StallD    (o_StallD),
    .o_StallE    (o_StallE),
    .o_StallM    (o_StallM),
    .o_StallW    (o_StallW),
    .o_FlushD    (o_FlushD),
    .o_FlushE    (o_FlushE),
`ifdef HAZARD_PERF_CNT_EN
    .o_MemErr    (o_MemErr),
    .o_StallCycles(o_StallCycles)
`else
    .o_MemErr    (o_MemErr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RFW-1:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic rwe, rwm, rww, mre, mrm, brd, pcs, req, rdy;
  } stim_t;

  typedef struct {
    logic [7:0]  fwd;   // {AE, BE, AD, BD}
    logic [6:0]  stl;   // {F, D, E, M, W, FlushD, FlushE}
    logic        err;
    logic [31:0] perf;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state: consecutive unserved memory cycles, sticky error,
  // and stall cycles seen so far.
  int          m_wcnt = 0;
  bit          m_err  = 0;
  int unsigned m_perf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rsd = '0; s.rtd = '0; s.rse = '0; s.rte = '0;
    s.wre = '0; s.wrm = '0; s.wrw = '0;
    s.rwe = 0; s.rwm = 0; s.rww = 0; s.mre = 0; s.mrm = 0;
    s.brd = 0; s.pcs = 0; s.req = 0; s.rdy = 0;
    return s;
  endfunction

  function automatic stim_t rnd(input bit force_req);
    stim_t s;
    s.rsd = RFW'($urandom_range(0, 3)); s.rtd = RFW'($urandom_range(0, 3));
    s.rse = RFW'($urandom_range(0, 3)); s.rte = RFW'($urandom_range(0, 3));
    s.wre = RFW'($urandom_range(0, 3)); s.wrm = RFW'($urandom_range(0, 3));
    s.wrw = RFW'($urandom_range(0, 3));
    s.rwe = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
    s.rww = 1'($urandom_range(0, 1)); s.mre = 1'($urandom_range(0, 1));
    s.mrm = 1'($urandom_range(0, 1)); s.brd = 1'($urandom_range(0, 1));
    s.pcs = 1'($urandom_range(0, 1));
    s.req = force_req ? 1'b1 : ($urandom_range(0, 3) == 0);
    s.rdy = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    logic [2:0] fa, fb;
    bit ad, bd, lw, br, mem, front;
    fa = 3'd0;
    if (s.rwm && s.wrm != 0 && s.wrm == s.rse)      fa = 3'd2;
    else if (s.rww && s.wrw != 0 && s.wrw == s.rse) fa = 3'd1;
    fb = 3'd0;
    if (s.rwm && s.wrm != 0 && s.wrm == s.rte)      fb = 3'd2;
    else if (s.rww && s.wrw != 0 && s.wrw == s.rte) fb = 3'd1;
    ad = (s.rsd != 0) && s.rwm && (s.wrm == s.rsd);
    bd = (s.rtd != 0) && s.rwm && (s.wrm == s.rtd);
    lw = s.mre && s.wre != 0 && (s.wre == s.rsd || s.wre == s.rtd);
    br = s.brd && ((s.rwe && s.wre != 0 && (s.wre == s.rsd || s.wre == s.rtd)) ||
                   (s.mrm && s.wrm != 0 && (s.wrm == s.rsd || s.wrm == s.rtd)));
    mem   = (s.req && !s.rdy) || m_err;
    front = mem || lw || br;
    e.fwd  = {fa, fb, ad, bd};
    e.stl  = {front, front, mem, mem, mem, s.pcs && !front, !mem && (lw || br)};
    e.err  = m_err;
    e.perf = m_perf;
    e.cyc  = cyc;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.fwd = '0; e.stl = '0; e.err = 1'b0; e.perf = '0; e.cyc = cyc;
    return e;
  endfunction

  task automatic advance_model(input stim_t s, input exp_t e);
    if (e.stl[6] && m_perf != PERF_MAX) m_perf++;
    if (!m_err) begin
      if (s.req && !s.rdy) begin
        m_wcnt++;
        if (m_wcnt == TO) m_err = 1;
      end else begin
        m_wcnt = 0;
      end
    end
  endtask

  task automatic reset_model();
    m_wcnt = 0; m_err = 0; m_perf = 0;
  endtask

  task automatic apply(input stim_t s);
    rsd = s.rsd; rtd = s.rtd; rse = s.rse; rte = s.rte;
    wre = s.wre; wrm = s.wrm; wrw = s.wrw;
    rwe = s.rwe; rwm = s.rwm; rww = s.rww; mre = s.mre; mrm = s.mrm;
    brd = s.brd; pcs = s.pcs; req = s.req; rdy = s.rdy;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(s);
    e = predict(s);
    sb_q.push_back(e);
    advance_model(s, e);
    cyc++;
  endtask

  // Reset with busy random inputs: every output must still read 0.
  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply(rnd(1'b0));
      sb_q.push_back(zero_exp());
      cyc++;
    end
    reset_model();
  endtask

  // Monitor: compare whatever the driver predicted for this cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("fwd@%0d", e.cyc),
              32'({o_ForwardAE, o_ForwardBE, o_ForwardAD, o_ForwardBD}), 32'(e.fwd));
        check($sformatf("stall_flush@%0d", e.cyc),
              32'({o_StallF, o_StallD, o_StallE, o_StallM, o_StallW, o_FlushD, o_FlushE}),
              32'(e.stl));
        check($sformatf("memerr@%0d", e.cyc), 32'(o_MemErr), 32'(e.err));
`ifdef HAZARD_PERF_CNT_EN
        check($sformatf("stall_cycles@%0d", e.cyc), 32'(o_StallCycles), e.perf);
`endif
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    exp_t  e;
    int    err_age;

    reset_cycles(3);

    // Forward priority: M over W, then W alone, then register 0 ignored.
    s = idle(); s.rse = 5; s.rwm = 1; s.wrm = 5; s.rww = 1; s.wrw = 5;
    drive(s);
    s.rwm = 0;
    drive(s);
    s.rwm = 1; s.wrm = 0; s.wrw = 0;
    drive(s);
    s = idle(); s.rte = 7; s.rtd = 7; s.rwm = 1; s.wrm = 7;
    drive(s);

    // Load-use for exactly one cycle.
    s = idle(); s.mre = 1; s.wre = 8; s.rtd = 8;
    drive(s);
    drive(idle());

    // Taken branch without hazard, then with an E-stage dependency.
    s = idle(); s.brd = 1; s.pcs = 1; s.rsd = 3; s.rtd = 4;
    drive(s);
    s.rwe = 1; s.wre = 3;
    drive(s);
    s = idle(); s.brd = 1; s.rsd = 2; s.mrm = 1; s.wrm = 2;
    drive(s);

    // Three-cycle memory wait, ready, then free.
    s = idle(); s.req = 1;
    repeat (3) drive(s);
    s.rdy = 1;
    drive(s);
    drive(idle());

    // Ready with request in the same cycle: no stall.
    s = idle(); s.req = 1; s.rdy = 1;
    drive(s);

    // Timeout: error after the fourth wait cycle, sticky past ready.
    s = idle(); s.req = 1;
    repeat (TO) drive(s);
    s.rdy = 1;
    repeat (2) drive(s);
    repeat (2) drive(idle());
    reset_cycles(2);

    // Stall counter: one load-use cycle plus a three-cycle wait gives 4.
    s = idle(); s.mre = 1; s.wre = 9; s.rsd = 9;
    drive(s);
    s = idle(); s.req = 1;
    repeat (3) drive(s);
    s.rdy = 1;
    drive(s);
    repeat (2) drive(idle());
    reset_cycles(1);

    // Asynchronous reset mid-wait, between clock edges.
    s = idle(); s.req = 1;
    repeat (2) drive(s);
    s = rnd(1'b1); s.rdy = 0; s.rse = 1; s.rwm = 1; s.wrm = 1;
    @(posedge clk);
    #1;
    apply(s);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs",
          32'({o_ForwardAE, o_ForwardBE, o_ForwardAD, o_ForwardBD, o_StallF, o_StallD,
               o_StallE, o_StallM, o_StallW, o_FlushD, o_FlushE, o_MemErr}), 32'd0);
    rst = 1'b0;
    reset_model();
    e = predict(s);
    sb_q.push_back(e);
    advance_model(s, e);
    cyc++;
    // Counter restarted from zero: the error needs the full TO wait cycles.
    s = idle(); s.req = 1;
    repeat (TO) drive(s);
    reset_cycles(1);

    // Randomised run with periodic recovery from the error state.
    err_age = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_err && err_age > 5) begin
        reset_cycles(1 + int'($urandom_range(0, 1)));
        err_age = 0;
      end else begin
        drive(rnd(m_wcnt > 0 && !m_err));
        if (m_err) err_age++;
      end
    end

    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected responses never compared, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
